// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the decode/stall
// logic that drives its start pulses.
package multdiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MULT = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } md_state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } md_mode_e;

    localparam logic [4:0] ALU_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MUL   = 5'b00110;
    localparam logic [4:0] ALU_DIV   = 5'b00111;

    localparam int MD_WIDTH        = 32;
    localparam int MULTDIV_LATENCY = MD_WIDTH + 1;

endpackage

// File: rtl/multdiv_iter_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring
// divide step, selected by mode_i.
module multdiv_iter_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [2*WIDTH-1:0] sreg_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  md_mode_e           mode_i,
    output logic [2*WIDTH-1:0] sreg_o
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] rem_sh_s;
    logic [WIDTH:0] trial_s;

    // Multiply: add multiplicand into the high half when the low bit is set, then
    // shift right. Divide: shift left, keep the trial difference if it did not borrow.
    always_comb begin
        sum_s    = {1'b0, sreg_i[2*WIDTH-1:WIDTH]}
                 + (sreg_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
        rem_sh_s = sreg_i[2*WIDTH-1:WIDTH-1];
        trial_s  = rem_sh_s - {1'b0, operand_i};
        if (mode_i == MODE_MUL) begin
            sreg_o = {sum_s, sreg_i[WIDTH-1:1]};
        end else if (trial_s[WIDTH]) begin
            sreg_o = {sreg_i[2*WIDTH-2:0], 1'b0};
        end else begin
            sreg_o = {trial_s[WIDTH-1:0], sreg_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/multdiv_unit.sv
// Fixed-latency signed multiply/divide unit: FSM, operand latches, iteration
// counter, sign fix-up and exception detection around multdiv_iter_step.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    md_state_e          state_q, state_d;
    md_mode_e           mode_s;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_q, neg_d;
    logic               dz_q, dz_d;
    logic               dexc_q, dexc_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               exc_q, exc_d;
    logic [2*WIDTH-1:0] step_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     prod_top_s;
    logic [WIDTH-1:0]   quot_s;
    logic               start_s;

    // Datapath mode follows the operation in flight.
    always_comb begin
        if (state_q == S_DIV) begin
            mode_s = MODE_DIV;
        end else begin
            mode_s = MODE_MUL;
        end
    end

    multdiv_iter_step #(.WIDTH(WIDTH)) u_step (
        .sreg_i    (sreg_q),
        .operand_i (opnd_q),
        .mode_i    (mode_s),
        .sreg_o    (step_s)
    );

    // Next-state, latching and result fix-up; a start pulse always wins over the
    // current operation so an aborted operation can never reach DONE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sreg_d     = sreg_q;
        opnd_d     = opnd_q;
        neg_d      = neg_q;
        dz_d       = dz_q;
        dexc_d     = dexc_q;
        res_d      = res_q;
        exc_d      = exc_q;
        start_s    = ctrl_MULT | ctrl_DIV;
        prod_s     = neg_q ? (-step_s) : step_s;
        prod_top_s = prod_s[2*WIDTH-1:WIDTH-1];
        quot_s     = neg_q ? (-step_s[WIDTH-1:0]) : step_s[WIDTH-1:0];

        if (start_s) begin
            state_d = ctrl_MULT ? S_MULT : S_DIV;
            cnt_d   = {CW{1'b0}};
            neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_d    = (data_operandB == {WIDTH{1'b0}});
            dexc_d  = (data_operandB == {WIDTH{1'b0}})
                    | ((data_operandA == MIN_NEG) & (data_operandB == {WIDTH{1'b1}}));
            if (ctrl_MULT) begin
                sreg_d = {{WIDTH{1'b0}}, magnitude(data_operandB)};
                opnd_d = magnitude(data_operandA);
            end else begin
                sreg_d = {{WIDTH{1'b0}}, magnitude(data_operandA)};
                opnd_d = magnitude(data_operandB);
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_MULT, S_DIV: begin
                    sreg_d = step_s;
                    cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                        if (state_q == S_MULT) begin
                            res_d = prod_s[WIDTH-1:0];
                            exc_d = !((&prod_top_s) || !(|prod_top_s));
                        end else begin
                            res_d = dz_q ? {WIDTH{1'b0}} : quot_s;
                            exc_d = dexc_q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, operand and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            sreg_q  <= {(2*WIDTH){1'b0}};
            opnd_q  <= {WIDTH{1'b0}};
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            dexc_q  <= 1'b0;
            res_q   <= {WIDTH{1'b0}};
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            dexc_q  <= dexc_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == S_DONE);
    assign busy           = (state_q == S_MULT) || (state_q == S_DIV);

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Iterative signed 32-bit multiply/divide unit on the responder side of the processor's mult/div stall handshake. The X stage pulses `ctrl_MULT` or `ctrl_DIV` with operands. The unit computes for a fixed number of cycles, then pulses `data_resultRDY`. The hazard/stall logic holds the pipeline from the start pulse until it sees that ready pulse. Latency is fixed, so the stall logic never has to guess.

## Interface
- `WIDTH`, default 32: operand and result width; iteration count equals `WIDTH`.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE and zeroes all outputs.
- `ctrl_MULT`  in  1  one-cycle start pulse for a signed multiply.
- `ctrl_DIV`  in  1  one-cycle start pulse for a signed divide.
- `data_operandA`  in  WIDTH  multiplicand or dividend; sampled only on a start cycle.
- `data_operandB`  in  WIDTH  multiplier or divisor; sampled only on a start cycle.
- `data_result`  out  WIDTH  product (low WIDTH bits) or quotient.
- `data_exception`  out  1  overflow or divide-by-zero flag, qualified by `data_resultRDY`.
- `data_resultRDY`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while an operation is in flight.

## Operation
- States: IDLE, MULT, DIV, DONE.
- IDLE → MULT on `ctrl_MULT`; IDLE → DIV on `ctrl_DIV`.
  - Operands, magnitudes and result sign are latched on that edge.
  - The iteration counter is cleared on that edge.
- MULT: radix-2 shift-add on operand magnitudes into a 2·WIDTH accumulator, one bit per cycle.
- DIV: restoring division on magnitudes, one quotient bit per cycle.
- MULT/DIV → DONE when the counter reaches WIDTH−1; DONE → IDLE unconditionally.
- Sign fix-up on the DONE transition: the result is negated if the operand signs differ.
- Multiply exception: set when the full 2·WIDTH signed product does not fit in WIDTH signed bits. The result is still the low WIDTH bits.
- Divide rules:
  - Quotient truncates toward zero; the remainder is discarded.
  - Divisor 0: result 0, exception 1.
  - 0x80000000 / −1: result 0x80000000, exception 1.
- Simultaneous `ctrl_MULT` and `ctrl_DIV`: multiply wins.
- A start pulse in any state, including MULT, DIV and DONE, aborts the current operation and restarts with the new operands. An aborted operation never produces `data_resultRDY`.
- `data_result` and `data_exception` update only on entry to DONE. They hold their value until the next DONE or reset.

## Timing
- Reset values: `data_result` 0, `data_exception` 0, `data_resultRDY` 0, `busy` 0; state IDLE, counter 0.
- Start pulse sampled at the end of cycle 0.
- `busy` is 1 in cycles 1..WIDTH.
- `data_resultRDY` is 1 in cycle WIDTH+1 only (33 for WIDTH=32), with result and exception valid in that same cycle.
- `busy` is 0 in the DONE cycle.
- Divide-by-zero and overflow cases take the same latency; there is no early exit.
- A start pulse in the DONE cycle is accepted: RDY still pulses that cycle, and the new operation's RDY comes WIDTH+1 cycles later.
- Reset asserted mid-operation: outputs zero immediately (asynchronously), and no RDY follows reset release.
- Back-to-back throughput: one operation per WIDTH+1 cycles.

## Structure
Shared package `multdiv_pkg` holds:
- the state enum;
- ALU opcode constants `ALU_MUL` = 5'b00110 and `ALU_DIV` = 5'b00111, plus R-type opcode 5'b00000, which the decode/stall logic also uses;
- the `MULTDIV_LATENCY` = WIDTH+1 constant.

One sub-module, `multdiv_iter_step`, is a combinational single-iteration datapath:
- inputs: shift register, divisor/multiplicand and mode;
- outputs: next shift-register value;
- used by both MULT and DIV.

The top level holds the FSM, counter, operand latches, sign fix-up and exception logic.

## Test plan
- Reset and idle: assert reset mid-idle → all outputs 0. Hold `ctrl_*` low for 100 cycles → no `data_resultRDY`, `busy` stays 0.
- Multiply, no overflow: `ctrl_MULT`, A = −7, B = 6 → in cycle 33 `data_result` = −42 (0xFFFFFFD6), exception 0; RDY high that single cycle.
- Multiply overflow: A = 0x00010000, B = 0x00010000 → result 0x00000000, exception 1 at cycle 33.
- Divide cases:
  - A = −100, B = 7 → result −14, exception 0.
  - A = 5, B = 0 → result 0, exception 1.
  - A = 0x80000000, B = −1 → result 0x80000000, exception 1.
  - Each case: RDY at cycle 33.
- Abort: `ctrl_DIV` at cycle 0, then `ctrl_MULT` (3 × 4) at cycle 10 → a single RDY at cycle 43 with result 12. No RDY at cycle 33.
- Edge cases:
  - Both ctrls high together (A = 2, B = 3) → result 6.
  - Start pulse in the DONE cycle → RDY in that cycle and again 33 cycles later.
  - Reset at cycle 20 of a multiply → no RDY after release.
